// File: rtl/i2cs_pkg.sv
// Shared constants for the I2C slave pin-side conditioner.
package i2cs_pkg;

  localparam int unsigned LEN_W_DEF  = 8;
  localparam logic        IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/i2cs_bus_conditioner_if.sv
// Pad, register and engine signals around the I2C bus conditioner.
interface i2cs_bus_conditioner_if
  import i2cs_pkg::*;
#(
  parameter int unsigned LEN_W = LEN_W_DEF
);

  logic             i2c_scl_i;
  logic             i2c_sda_i;
  logic             i2c_enabled_i;
  logic [LEN_W-1:0] i2c_debounce_len_i;
  logic [LEN_W-1:0] i2c_scl_delay_len_i;
  logic [LEN_W-1:0] i2c_sda_delay_len_i;
  logic             i2c_sda_drive_low_i;
  logic             i2c_scl_filt_o;
  logic             i2c_sda_filt_o;
  logic             i2c_start_o;
  logic             i2c_stop_o;
  logic             i2c_scl_sample_o;
  logic             i2c_scl_fall_o;
  logic             i2c_bus_busy_o;
  logic             i2c_sda_oe_o;

  modport slave (
    input  i2c_scl_i, i2c_sda_i, i2c_enabled_i, i2c_debounce_len_i,
           i2c_scl_delay_len_i, i2c_sda_delay_len_i, i2c_sda_drive_low_i,
    output i2c_scl_filt_o, i2c_sda_filt_o, i2c_start_o, i2c_stop_o,
           i2c_scl_sample_o, i2c_scl_fall_o, i2c_bus_busy_o, i2c_sda_oe_o
  );

  modport master (
    output i2c_scl_i, i2c_sda_i, i2c_enabled_i, i2c_debounce_len_i,
           i2c_scl_delay_len_i, i2c_sda_delay_len_i, i2c_sda_drive_low_i,
    input  i2c_scl_filt_o, i2c_sda_filt_o, i2c_start_o, i2c_stop_o,
           i2c_scl_sample_o, i2c_scl_fall_o, i2c_bus_busy_o, i2c_sda_oe_o
  );

endinterface

// File: rtl/i2cs_line_filter.sv
// Pin synchroniser plus debounce: the filtered level follows the synced pin
// only after it has differed for max(len,1) consecutive cycles.
module i2cs_line_filter
  import i2cs_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LEN_W       = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pin,
  input  logic [LEN_W-1:0] len,
  output logic             filt
);

  localparam logic [LEN_W:0] CNT_ONE = {{LEN_W{1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync;
  logic [LEN_W-1:0]       cnt;
  logic [LEN_W:0]         cnt_nxt;
  logic [LEN_W:0]         len_eff;
  logic                   synced;

  assign synced = sync[SYNC_STAGES-1];

  always_comb begin
    cnt_nxt = {1'b0, cnt} + CNT_ONE;
    len_eff = (len == '0) ? CNT_ONE : {1'b0, len};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {SYNC_STAGES{IDLE_LEVEL}};
      cnt  <= '0;
      filt <= IDLE_LEVEL;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pin};
      if (synced == filt) begin
        cnt <= '0;
      end else if (cnt_nxt >= len_eff) begin
        filt <= synced;
        cnt  <= '0;
      end else begin
        cnt <= cnt_nxt[LEN_W-1:0];
      end
    end
  end

endmodule

// File: rtl/i2cs_bus_conditioner.sv
// I2C pin front end: filtered SCL/SDA, START/STOP detect, SCL sample/fall
// strobes, bus-busy tracking and delayed SDA pad enable.
module i2cs_bus_conditioner
  import i2cs_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LEN_W       = LEN_W_DEF
) (
  input  logic                   apb_pclk_i,
  input  logic                   apb_presetn_i,
  i2cs_bus_conditioner_if.slave  bus
);

  localparam logic [LEN_W:0] CNT_ONE = {{LEN_W{1'b0}}, 1'b1};

  logic scl_f, sda_f, scl_q, sda_q, en, en_q;
  logic scl_rise, scl_fall, cond_ok, start_det, stop_det;
  logic start_r, stop_r, sample_r, fall_r, busy_r, oe_r;
  logic smp_pend;
  logic [LEN_W-1:0] smp_cnt, sda_cnt;
  logic [LEN_W:0]   smp_nxt, smp_len, sda_nxt, sda_len;

  i2cs_line_filter #(.SYNC_STAGES(SYNC_STAGES), .LEN_W(LEN_W)) u_scl_filter (
    .clk(apb_pclk_i), .rst_n(apb_presetn_i), .pin(bus.i2c_scl_i),
    .len(bus.i2c_debounce_len_i), .filt(scl_f)
  );

  i2cs_line_filter #(.SYNC_STAGES(SYNC_STAGES), .LEN_W(LEN_W)) u_sda_filter (
    .clk(apb_pclk_i), .rst_n(apb_presetn_i), .pin(bus.i2c_sda_i),
    .len(bus.i2c_debounce_len_i), .filt(sda_f)
  );

  assign en = bus.i2c_enabled_i;

  // en_q gates START/STOP so a level change landing on re-enable is not reported
  always_comb begin
    scl_rise  = en & scl_f & ~scl_q;
    scl_fall  = en & ~scl_f & scl_q;
    cond_ok   = en & en_q & scl_f & scl_q;
    start_det = cond_ok & sda_q & ~sda_f;
    stop_det  = cond_ok & ~sda_q & sda_f;
    smp_len   = (bus.i2c_scl_delay_len_i == '0) ? CNT_ONE : {1'b0, bus.i2c_scl_delay_len_i};
    smp_nxt   = scl_rise ? CNT_ONE : ({1'b0, smp_cnt} + CNT_ONE);
    sda_len   = (bus.i2c_sda_delay_len_i == '0) ? CNT_ONE : {1'b0, bus.i2c_sda_delay_len_i};
    sda_nxt   = {1'b0, sda_cnt} + CNT_ONE;
  end

  always_ff @(posedge apb_pclk_i or negedge apb_presetn_i) begin
    if (!apb_presetn_i) begin
      scl_q <= IDLE_LEVEL;
      sda_q <= IDLE_LEVEL;
      en_q  <= 1'b0;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
      en_q  <= en;
    end
  end

  always_ff @(posedge apb_pclk_i or negedge apb_presetn_i) begin
    if (!apb_presetn_i) begin
      start_r <= 1'b0;
      stop_r  <= 1'b0;
      fall_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      start_r <= start_det;
      stop_r  <= stop_det;
      fall_r  <= scl_fall;
      if (!en)           busy_r <= 1'b0;
      else if (start_det) busy_r <= 1'b1;
      else if (stop_det)  busy_r <= 1'b0;
    end
  end

  // Elapsed-cycle up-counter so a live length change compares against the new value
  always_ff @(posedge apb_pclk_i or negedge apb_presetn_i) begin
    if (!apb_presetn_i) begin
      sample_r <= 1'b0;
      smp_pend <= 1'b0;
      smp_cnt  <= '0;
    end else begin
      sample_r <= 1'b0;
      if (!en || scl_fall) begin
        smp_pend <= 1'b0;
        smp_cnt  <= '0;
      end else if (scl_rise || smp_pend) begin
        if (smp_nxt >= smp_len) begin
          sample_r <= 1'b1;
          smp_pend <= 1'b0;
          smp_cnt  <= '0;
        end else begin
          smp_pend <= 1'b1;
          smp_cnt  <= smp_nxt[LEN_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge apb_pclk_i or negedge apb_presetn_i) begin
    if (!apb_presetn_i) begin
      oe_r    <= 1'b0;
      sda_cnt <= '0;
    end else if (!en) begin
      oe_r    <= 1'b0;
      sda_cnt <= '0;
    end else if (bus.i2c_sda_drive_low_i != oe_r) begin
      if (sda_nxt >= sda_len) begin
        oe_r    <= bus.i2c_sda_drive_low_i;
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_nxt[LEN_W-1:0];
      end
    end else begin
      sda_cnt <= '0;
    end
  end

  assign bus.i2c_scl_filt_o   = scl_f;
  assign bus.i2c_sda_filt_o   = sda_f;
  assign bus.i2c_start_o      = start_r;
  assign bus.i2c_stop_o       = stop_r;
  assign bus.i2c_scl_sample_o = sample_r;
  assign bus.i2c_scl_fall_o   = fall_r;
  assign bus.i2c_bus_busy_o   = busy_r;
  assign bus.i2c_sda_oe_o     = oe_r;

endmodule

// File: tb/tb_i2cs_bus_conditioner.sv
// Scoreboard bench: stimulus queues expected output events with their cycle,
// a negedge monitor pops and compares every observed event.
module tb_i2cs_bus_conditioner;

  localparam int unsigned LEN_W = 8;

  typedef struct {
    string       name;
    int unsigned cyc;
  } evt_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  int unsigned cyc   = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit          mon_on = 1'b0;
  evt_t        exp_q[$];
  logic        p_scl = 1'b1, p_sda = 1'b1, p_busy = 1'b0, p_oe = 1'b0;

  i2cs_bus_conditioner_if #(.LEN_W(LEN_W)) bus ();

  i2cs_bus_conditioner #(.SYNC_STAGES(2), .LEN_W(LEN_W)) dut (
    .apb_pclk_i   (clk),
    .apb_presetn_i(rst_n),
    .bus          (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input string nm, input int unsigned c);
    evt_t e;
    e.name = nm;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic check(input string nm, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", nm, act, req);
    end
  endtask

  task automatic log_evt(input string nm);
    evt_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL evt: got %s @%0d, want no event", nm, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.name != nm || e.cyc != cyc) begin
        n_bad++;
        $display("FAIL evt: got %s @%0d, want %s @%0d", nm, cyc, e.name, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (bus.i2c_scl_filt_o !== p_scl) log_evt(bus.i2c_scl_filt_o ? "scl_filt=1" : "scl_filt=0");
      if (bus.i2c_sda_filt_o !== p_sda) log_evt(bus.i2c_sda_filt_o ? "sda_filt=1" : "sda_filt=0");
      if (bus.i2c_start_o)      log_evt("start");
      if (bus.i2c_stop_o)       log_evt("stop");
      if (bus.i2c_scl_sample_o) log_evt("sample");
      if (bus.i2c_scl_fall_o)   log_evt("scl_fall");
      if (bus.i2c_bus_busy_o !== p_busy) log_evt(bus.i2c_bus_busy_o ? "busy=1" : "busy=0");
      if (bus.i2c_sda_oe_o !== p_oe)     log_evt(bus.i2c_sda_oe_o ? "oe=1" : "oe=0");
    end
    p_scl  = bus.i2c_scl_filt_o;
    p_sda  = bus.i2c_sda_filt_o;
    p_busy = bus.i2c_bus_busy_o;
    p_oe   = bus.i2c_sda_oe_o;
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_scl_filt"}, bus.i2c_scl_filt_o,   1'b1);
    check({tag, "_sda_filt"}, bus.i2c_sda_filt_o,   1'b1);
    check({tag, "_start"},    bus.i2c_start_o,      1'b0);
    check({tag, "_stop"},     bus.i2c_stop_o,       1'b0);
    check({tag, "_sample"},   bus.i2c_scl_sample_o, 1'b0);
    check({tag, "_fall"},     bus.i2c_scl_fall_o,   1'b0);
    check({tag, "_busy"},     bus.i2c_bus_busy_o,   1'b0);
    check({tag, "_oe"},       bus.i2c_sda_oe_o,     1'b0);
  endtask

  initial begin
    int unsigned e;
    bus.i2c_scl_i           = 1'b1;
    bus.i2c_sda_i           = 1'b1;
    bus.i2c_enabled_i       = 1'b1;
    bus.i2c_debounce_len_i  = 8'd20;
    bus.i2c_scl_delay_len_i = 8'd20;
    bus.i2c_sda_delay_len_i = 8'd8;
    bus.i2c_sda_drive_low_i = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset_values("rst");
    tick(3);
    rst_n = 1'b1;
    tick(4);
    mon_on = 1'b1;

    // debounce 20: 15-cycle glitch is swallowed, 30-cycle low passes
    e = cyc; bus.i2c_scl_i = 1'b0;
    tick(15); bus.i2c_scl_i = 1'b1;
    tick(30);
    e = cyc; bus.i2c_scl_i = 1'b0;
    expect_at("scl_filt=0", e + 22);
    expect_at("scl_fall",   e + 23);
    tick(30);
    e = cyc; bus.i2c_scl_i = 1'b1;
    expect_at("scl_filt=1", e + 22);
    expect_at("sample",     e + 42);
    tick(50);

    // START / STOP with debounce 4
    bus.i2c_debounce_len_i = 8'd4;
    tick(2);
    e = cyc; bus.i2c_sda_i = 1'b0;
    expect_at("sda_filt=0", e + 6);
    expect_at("start",      e + 7);
    expect_at("busy=1",     e + 7);
    tick(20);
    e = cyc; bus.i2c_sda_i = 1'b1;
    expect_at("sda_filt=1", e + 6);
    expect_at("stop",       e + 7);
    expect_at("busy=0",     e + 7);
    tick(20);

    // simultaneous SCL/SDA edges: only the SCL path reacts
    e = cyc; bus.i2c_scl_i = 1'b0; bus.i2c_sda_i = 1'b0;
    expect_at("scl_filt=0", e + 6);
    expect_at("sda_filt=0", e + 6);
    expect_at("scl_fall",   e + 7);
    tick(20);
    e = cyc; bus.i2c_scl_i = 1'b1; bus.i2c_sda_i = 1'b1;
    expect_at("scl_filt=1", e + 6);
    expect_at("sda_filt=1", e + 6);
    expect_at("sample",     e + 26);
    tick(40);

    // SCL high for 10 filtered cycles: pending sample cancelled
    e = cyc; bus.i2c_scl_i = 1'b0;
    expect_at("scl_filt=0", e + 6);
    expect_at("scl_fall",   e + 7);
    tick(20);
    e = cyc; bus.i2c_scl_i = 1'b1;
    expect_at("scl_filt=1", e + 6);
    tick(10); bus.i2c_scl_i = 1'b0;
    expect_at("scl_filt=0", e + 16);
    expect_at("scl_fall",   e + 17);
    tick(30);

    // scl delay 0: sample in the cycle after the rise
    bus.i2c_scl_delay_len_i = 8'd0;
    e = cyc; bus.i2c_scl_i = 1'b1;
    expect_at("scl_filt=1", e + 6);
    expect_at("sample",     e + 7);
    tick(20);

    // SDA output delay 8, then a 3-cycle request that must not pass
    e = cyc; bus.i2c_sda_drive_low_i = 1'b1;
    expect_at("oe=1", e + 8);
    tick(20);
    e = cyc; bus.i2c_sda_drive_low_i = 1'b0;
    expect_at("oe=0", e + 8);
    tick(20);
    bus.i2c_sda_drive_low_i = 1'b1;
    tick(3); bus.i2c_sda_drive_low_i = 1'b0;
    tick(20);
    bus.i2c_sda_delay_len_i = 8'd0;
    e = cyc; bus.i2c_sda_drive_low_i = 1'b1;
    expect_at("oe=1", e + 1);
    tick(10);

    // enable dropped mid-transfer with oe=1 and bus busy
    e = cyc; bus.i2c_sda_i = 1'b0;
    expect_at("sda_filt=0", e + 6);
    expect_at("start",      e + 7);
    expect_at("busy=1",     e + 7);
    tick(15);
    e = cyc; bus.i2c_enabled_i = 1'b0; bus.i2c_sda_drive_low_i = 1'b0;
    expect_at("busy=0", e + 1);
    expect_at("oe=0",   e + 1);
    tick(5);

    // SDA rise filtered while disabled and landing as enable returns: no STOP
    e = cyc; bus.i2c_sda_i = 1'b1;
    expect_at("sda_filt=1", e + 6);
    tick(6); bus.i2c_enabled_i = 1'b1;
    tick(20);

    // async reset mid-count with SCL filtered low
    e = cyc; bus.i2c_scl_i = 1'b0;
    expect_at("scl_filt=0", e + 6);
    expect_at("scl_fall",   e + 7);
    tick(12);
    bus.i2c_sda_delay_len_i = 8'd8;
    bus.i2c_sda_drive_low_i = 1'b1;
    tick(3);
    check("pre_rst_scl_filt", bus.i2c_scl_filt_o, 1'b0);
    #2;
    mon_on = 1'b0;
    rst_n  = 1'b0;
    #1 check_reset_values("async_rst");
    bus.i2c_scl_i = 1'b1;
    bus.i2c_sda_drive_low_i = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(5);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_events: got %0d left, want 0 (next %s @%0d)",
               exp_q.size(), exp_q[0].name, exp_q[0].cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2cs_bus_conditioner.md
Name: i2cs_bus_conditioner

Overview:
Pin-side front end of the I2C peripheral, between the raw SCL/SDA pads and the I2C protocol engine.
- Synchronises and debounces SCL/SDA using the register-programmed debounce length.
- Detects START/STOP and produces SCL-delayed sample strobes and SCL falling-edge strobes.
- Applies the programmed SDA output delay to the engine's drive request before it reaches the pad enable.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on each pin input (min 2).
LEN_W, 8, width of debounce/delay length inputs and internal counters.

Ports:
apb_pclk_i  in  1  system clock
apb_presetn_i  in  1  asynchronous active-low reset
i2c_scl_i  in  1  raw SCL pin
i2c_sda_i  in  1  raw SDA pin
i2c_enabled_i  in  1  block enable from register module
i2c_debounce_len_i  in  LEN_W  stable cycles required before a filtered level changes
i2c_scl_delay_len_i  in  LEN_W  cycles from filtered SCL rise to sample strobe
i2c_sda_delay_len_i  in  LEN_W  cycles a drive-request change waits before reaching the pad
i2c_sda_drive_low_i  in  1  engine request: 1 = pull SDA low
i2c_scl_filt_o  out  1  filtered SCL level
i2c_sda_filt_o  out  1  filtered SDA level
i2c_start_o  out  1  one-cycle START (including repeated START) pulse
i2c_stop_o  out  1  one-cycle STOP pulse
i2c_scl_sample_o  out  1  one-cycle strobe to sample SDA
i2c_scl_fall_o  out  1  one-cycle strobe on filtered SCL falling edge
i2c_bus_busy_o  out  1  high between START and STOP
i2c_sda_oe_o  out  1  pad output enable (1 = drive 0)

Behaviour:
- Clock/reset: one clock, apb_pclk_i; reset apb_presetn_i is asynchronous, active-low.
- Reset values: scl_filt=1, sda_filt=1, all strobes 0, bus_busy=0, sda_oe=0; synchroniser flops 1; counters 0.
- Synchroniser: SYNC_STAGES flops per pin, reset to 1.
- Debounce, per line:
  - Counter increments while synced value != filtered value; clears to 0 when they are equal.
  - Filtered value takes the synced value when counter+1 >= max(len,1); counter then clears.
  - A glitch shorter than len cycles never reaches the filtered output.
  - Latency from pin edge to filtered edge is SYNC_STAGES + max(len,1) cycles.
- Edge/condition detect uses registered previous filtered values:
  - START = SDA 1->0 while SCL stays 1.
  - STOP = SDA 0->1 while SCL stays 1.
  - SCL and SDA filtered edges in the same cycle: the SCL edge is reported; no START/STOP.
- bus_busy: set on START, cleared on STOP. A repeated START keeps it set and still pulses i2c_start_o.
- Sample strobe:
  - On a filtered SCL rise, the delay counter loads scl_delay_len.
  - i2c_scl_sample_o pulses when the counter expires. len=0 pulses in the cycle after the rise.
  - A filtered SCL fall before expiry cancels the pending strobe; no pulse is issued.
- i2c_scl_fall_o pulses in the cycle after the filtered SCL falls (registered).
- SDA output delay:
  - When i2c_sda_drive_low_i differs from sda_oe, the counter runs. sda_oe takes the request after sda_delay_len cycles (0 -> next cycle).
  - A request that reverts mid-count clears the counter; sda_oe stays unchanged.
- Enable low:
  - Strobes forced 0, bus_busy cleared, sda_oe forced 0, delay counters cleared.
  - Synchronisers and debounce keep running so filtered levels are valid on re-enable.
  - No START/STOP is reported in the cycle enable rises.
- Length inputs are sampled live. A length change mid-count compares against the new value; reaching >= len fires immediately.

Decomposition:
- Shared package i2cs_pkg: LEN_W default, reset-level constants (IDLE_LEVEL=1).
- One sub-module i2cs_line_filter (synchroniser + debounce counter), instantiated once for SCL and once for SDA.
- Condition detect, sample/fall strobes and SDA delay live in the top.

Test Plan:
- Debounce=20, SYNC=2; SDA stays high; SCL pin drops 0 for 15 cycles -> scl_filt stays 1 and no strobes. A 30-cycle low -> scl_filt falls 22 cycles after the pin edge; scl_fall pulses once.
- SCL high, SDA high->low, debounce=4 -> start=1 for exactly one cycle and bus_busy=1. SDA low->high later -> stop pulse, bus_busy=0.
- SCL and SDA pins toggle in the same clock, debounce=4 -> scl_fall or scl rise strobe path only; start=stop=0.
- scl_delay=20; SCL high for 50 cycles -> one sample pulse 20 cycles after the filtered rise. SCL high for only 10 filtered cycles -> no sample pulse.
- sda_delay=8; drive_low 0->1 -> sda_oe rises 8 cycles later. Drive_low pulsed high for 3 cycles -> sda_oe stays 0.
- Enable dropped mid-transfer with sda_oe=1 -> sda_oe=0 and bus_busy=0 next cycle. Async reset asserted mid-count -> all outputs at reset values immediately, without waiting for a clock edge.
